// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   N-input streaming multiplexer with a valid/ready handshake on every lane
//   and a registered output stage. Each cycle one source is granted, either
//   by an explicit index (mode 0) or by round-robin arbitration starting
//   after the last-served lane (mode 1).
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        synchronous reset, active-high
//   in_valid   per-lane valid
//   in_data    flattened lane data, lane i at [i*WIDTH +: WIDTH]
//   in_ready   per-lane ready, one-hot or zero
//   mode       0 = fixed select, 1 = round-robin
//   sel        lane index used in mode 0 (out-of-range never grants)
//   out_valid  output register holds a valid word
//   out_data   registered selected data
//   out_sel    index of the lane that supplied out_data
//   out_ready  consumer accepts out_data this cycle
module stream_mux_rr #(
  parameter int  WIDTH  = 32,
  parameter int  NUM_IN = 8,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  // Unpacked view of the flattened input bus.
  logic [WIDTH-1:0] lane_data [NUM_IN];

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
    assign lane_data[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [SEL_W-1:0] out_sel_reg;
  logic [SEL_W-1:0] ptr_reg;       // last granted lane

  logic             load_en;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;

  // The output register may be refilled when empty or being drained.
  assign load_en = !out_valid_reg || out_ready;

  // Grant selection. The fixed-mode search compares sel against every legal
  // index, so a sel beyond NUM_IN-1 simply matches nothing.
  always_comb begin
    int cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    cand        = 0;
    if (!mode) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
          grant_data  = lane_data[i];
        end
      end
    end else begin
      // Walk ptr+1, ptr+2, ... with wraparound; the first valid lane wins.
      // ptr < NUM_IN and k <= NUM_IN, so one subtraction is enough modulo.
      for (int k = 1; k <= NUM_IN; k++) begin
        cand = int'(ptr_reg) + k;
        if (cand >= NUM_IN) begin
          cand = cand - NUM_IN;
        end
        if (!grant_valid && in_valid[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(cand);
          grant_data  = lane_data[cand];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ready
    assign in_ready[gi] = load_en && grant_valid &&
                          (grant_idx == SEL_W'(gi)) && !rst;
  end

  // A grant always coincides with a handshake on the granted lane, because a
  // lane is only granted while its valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      ptr_reg       <= SEL_W'(NUM_IN - 1);
    end else if (load_en) begin
      if (grant_valid) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= grant_data;
        out_sel_reg   <= grant_idx;
        ptr_reg       <= grant_idx;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;
  localparam int W  = 32;
  localparam int N  = 8;
  localparam int N5 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 8-lane instance
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic           mode;
  logic [2:0]     sel;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;
  logic           out_ready;
  logic [W-1:0]   lane [N];

  // 5-lane instance (non-power-of-2 channel count)
  logic [N5-1:0]   v5;
  logic [N5-1:0]   r5;
  logic [N5*W-1:0] d5;
  logic            mode5;
  logic [2:0]      sel5;
  logic            ov5;
  logic [W-1:0]    od5;
  logic [2:0]      os5;
  logic            ordy5;
  logic [W-1:0]    lane5 [N5];

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign in_data[gi*W +: W] = lane[gi];
  end
  for (genvar gi = 0; gi < N5; gi++) begin : g_pack5
    assign d5[gi*W +: W] = lane5[gi];
  end

  stream_mux_rr #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mode(mode), .sel(sel),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(W), .NUM_IN(N5)) dut5 (
    .clk(clk), .rst(rst),
    .in_valid(v5), .in_data(d5), .in_ready(r5),
    .mode(mode5), .sel(sel5),
    .out_valid(ov5), .out_data(od5), .out_sel(os5),
    .out_ready(ordy5)
  );

  int checks = 0;
  int errors = 0;

  // Expected output register contents, plus the scoreboard of accepted words.
  logic        m_valid;
  logic [W-1:0] m_data;
  logic [2:0]  m_sel;
  logic [34:0] sbq [$];
  logic [34:0] sbq5 [$];

  // One clock cycle on the 8-lane instance. exp_rdy is the handshake the test
  // expects this cycle; the accepted word is queued and must appear at the
  // output after the edge.
  task automatic tick(input logic [N-1:0] exp_rdy, input string tag);
    logic        le;
    logic        rst_at;
    logic [34:0] item;
    int          idx;
    @(negedge clk);
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL %s in_ready got %h exp %h", tag, in_ready, exp_rdy);
    end
    le     = !m_valid || out_ready;
    rst_at = rst;
    if (exp_rdy != '0) begin
      idx = 0;
      for (int i = 0; i < N; i++) if (exp_rdy[i]) idx = i;
      sbq.push_back({3'(idx), lane[idx]});
    end
    @(posedge clk);
    #1;
    if (rst_at) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = '0;
      sbq.delete();
    end else if (le) begin
      if (sbq.size() > 0) begin
        item    = sbq.pop_front();
        m_valid = 1'b1;
        m_sel   = item[34:32];
        m_data  = item[31:0];
      end else begin
        m_valid = 1'b0;
      end
    end
    checks++;
    if (out_valid !== m_valid) begin
      errors++;
      $display("FAIL %s out_valid got %b exp %b", tag, out_valid, m_valid);
    end
    if (m_valid || rst_at) begin
      checks++;
      if (out_data !== m_data || out_sel !== m_sel) begin
        errors++;
        $display("FAIL %s out got data %h sel %0d exp data %h sel %0d",
                 tag, out_data, out_sel, m_data, m_sel);
      end
    end
    $display("[%0t] %s in_ready=%h out_valid=%b out_data=%h out_sel=%0d",
             $time, tag, exp_rdy, out_valid, out_data, out_sel);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick('0, "rst");
    tick('0, "rst");
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) lane[i] = 32'hC0DE_0000 + i;
    in_valid  = 8'hFF;
    mode      = 1'b1;
    out_ready = 1'b1;
    do_reset();
    tick(8'h01, "reset_first_ch0");
    // Reset while a word is held under backpressure discards it.
    out_ready = 1'b0;
    rst       = 1'b1;
    tick('0, "reset_midxfer");
    rst = 1'b0;
    in_valid = '0;
    tick('0, "reset_idle");
  endtask

  task automatic test_fixed();
    do_reset();
    out_ready = 1'b1;
    mode      = 1'b0;
    sel       = 3'd3;
    lane[3]   = 32'hDEAD_BEEF;
    in_valid  = 8'h08;
    tick(8'h08, "fixed_sel3");
    sel = 3'd5;
    tick('0, "fixed_sel5_invalid");
    sel      = 3'd3;
    in_valid = 8'hFF;
    lane[3]  = 32'h0BAD_F00D;
    tick(8'h08, "fixed_sel3_allvalid");
  endtask

  task automatic test_rr_fair();
    for (int i = 0; i < N; i++) lane[i] = i;
    in_valid  = 8'hFF;
    mode      = 1'b1;
    out_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 10; k++) tick(8'(1 << (k % 8)), "rr_fair");
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    for (int i = 0; i < N; i++) lane[i] = 32'h5A00_0000 + i;
    out_ready = 1'b1;
    mode      = 1'b0;
    sel       = 3'd6;
    in_valid  = 8'h40;
    tick(8'h40, "sparse_seed_ch6");
    mode     = 1'b1;
    in_valid = 8'h05;
    tick(8'h01, "sparse_wrap_ch0");
    tick(8'h04, "sparse_ch2");
    tick(8'h01, "sparse_ch0_again");
    in_valid = '0;
    tick('0, "sparse_drain");
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < N; i++) lane[i] = 32'hA0 + i;
    lane[2]   = 32'h1234;
    out_ready = 1'b1;
    mode      = 1'b0;
    sel       = 3'd2;
    in_valid  = 8'h04;
    tick(8'h04, "bp_load_1234");
    out_ready = 1'b0;
    mode      = 1'b1;
    in_valid  = 8'hFF;
    for (int k = 0; k < 3; k++) tick('0, "bp_stall");
    out_ready = 1'b1;
    tick(8'h08, "bp_release_ch3");
    tick(8'h10, "bp_next_ch4");
    in_valid = '0;
    tick('0, "bp_empty");
  endtask

  // Out-of-range select on the 5-lane instance, then a wrap in round-robin.
  task automatic test_oor_sel();
    logic [2:0]    t_sel [4] = '{3'd6, 3'd5, 3'd4, 3'd4};
    logic          t_mode[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [N5-1:0] t_rdy [4] = '{5'h00, 5'h00, 5'h10, 5'h01};
    logic [34:0]   item;
    int            idx;
    do_reset();
    for (int i = 0; i < N5; i++) lane5[i] = 32'h5000_0000 + i;
    v5    = 5'h1F;
    ordy5 = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel5  = t_sel[s];
      mode5 = t_mode[s];
      @(negedge clk);
      checks++;
      if (r5 !== t_rdy[s]) begin
        errors++;
        $display("FAIL oor_step%0d in_ready got %h exp %h", s, r5, t_rdy[s]);
      end
      if (t_rdy[s] != '0) begin
        idx = 0;
        for (int i = 0; i < N5; i++) if (t_rdy[s][i]) idx = i;
        sbq5.push_back({3'(idx), lane5[idx]});
      end
      @(posedge clk);
      #1;
      checks++;
      if (sbq5.size() > 0) begin
        item = sbq5.pop_front();
        if (ov5 !== 1'b1 || od5 !== item[31:0] || os5 !== item[34:32]) begin
          errors++;
          $display("FAIL oor_step%0d out got v %b data %h sel %0d exp v 1 data %h sel %0d",
                   s, ov5, od5, os5, item[31:0], item[34:32]);
        end
      end else if (ov5 !== 1'b0) begin
        errors++;
        $display("FAIL oor_step%0d out_valid got %b exp 0", s, ov5);
      end
      $display("[%0t] oor_step%0d sel=%0d mode=%b in_ready=%h out_valid=%b out_sel=%0d",
               $time, s, t_sel[s], t_mode[s], r5, ov5, os5);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) lane[i] = '0;
    v5    = '0;
    mode5 = 1'b0;
    sel5  = '0;
    ordy5 = 1'b1;
    for (int i = 0; i < N5; i++) lane5[i] = '0;
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = '0;

    test_reset();
    test_fixed();
    test_rr_fair();
    test_sparse_wrap();
    test_backpressure();
    test_oor_sel();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
